bsg_lru_pseudo_tree_decode: RTL and testbench
=============================================

BSG_LRU_PSEUDO_TREE_DECODE -- requirements
Module: bsg_lru_pseudo_tree_decode

Interface
REQ-001 SHALL have parameter ways_p, default 8: number of cache ways; power of two, >= 2.
REQ-002 SHALL have derived localparam lg_ways_lp = max(1, clog2(ways_p)): way-index width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port v_i, input, 1 bit: way_id_i valid this cycle.
REQ-006 SHALL have port way_id_i, input, lg_ways_lp bits: accessed way index.
REQ-007 SHALL have port v_o, output, 1 bit: data_o/mask_o valid.
REQ-008 SHALL have port data_o, output, ways_p-1 bits: new pseudo-LRU tree bit values.
REQ-009 SHALL have port mask_o, output, ways_p-1 bits: tree bits to be written (1 = write).

Function
REQ-010 Tree numbering SHALL be: node 0 is the root; node i has left child 2i+1 and right child 2i+2; there are ways_p-1 nodes over lg_ways_lp levels.
REQ-011 At tree level L (root L=0), the path SHALL take way_id_i bit [lg_ways_lp-1-L]: 0 goes left, 1 goes right.
REQ-012 mask SHALL be 1 exactly on the lg_ways_lp nodes on the root-to-leaf path of way_id_i, and 0 elsewhere.
REQ-013 data SHALL equal, at each path node, the inverse of the way_id_i bit used at that node, so the node points away from the accessed way; non-path bits SHALL be 0.
REQ-014 Decode SHALL be combinational internally and registered at the outputs: v_i/way_id_i sampled at posedge N appear on v_o/data_o/mask_o after posedge N; latency is 1 cycle.
REQ-015 When v_i=1, the output registers SHALL load v_o=1 and the decoded data/mask.
REQ-016 When v_i=0, the output registers SHALL load v_o=0 and clear data_o and mask_o to 0 (no stale masks).
REQ-017 The block SHALL be fully pipelined: back-to-back v_i every cycle is accepted, with no stall or backpressure.
REQ-018 For ways_p=2 (single node), mask_o=1 and data_o=~way_id_i[0] when valid.
REQ-019 Every way_id_i value in 0..ways_p-1 is legal; there are no wrap or out-of-range cases.

Reset
REQ-020 Asserting reset_n_i=0 SHALL immediately (asynchronously) force v_o=0, data_o=0, mask_o=0.
REQ-021 Deassertion SHALL be synchronized by the integrator; the first capture SHALL occur on the first posedge with reset_n_i=1.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result; there is no other state.

Structure
REQ-023 No shared package is required; lg_ways_lp SHALL be computed locally with the codebase's safe-clog2 macro.
REQ-024 The combinational decoder SHALL be a sub-module, bsg_lru_pseudo_tree_decode_comb (ways_p; way_id_i -> data_o, mask_o), generate-loop per node, wrapped by a registered top.
REQ-025 The design SHALL be synthesizable, parameter-generic, with no latches.

Verification
REQ-026 ways_p=8, v_i=1, way_id_i=0 -> next cycle v_o=1, mask_o=7'b0001011, data_o=7'b0001011.
REQ-027 ways_p=8, way_id_i=7 -> mask_o=7'b1000101, data_o=7'b0000000; way_id_i=5 -> mask_o=7'b0100101, data_o=7'b0000100.
REQ-028 ways_p=8, sweep way_id_i 0..7 on consecutive cycles with v_i=1 -> eight consecutive valid outputs, each matching a reference model; popcount(mask_o)=3 and data_o & ~mask_o = 0 on every cycle.
REQ-029 v_i=0 after a valid beat -> next cycle v_o=0, data_o=0, mask_o=0.
REQ-030 reset_n_i driven low asynchronously between clock edges while v_o=1 -> outputs 0 without a clock edge; after release, first valid result after one posedge.
REQ-031 ways_p=2 and ways_p=16 sweeps -> per REQ-018, and mask popcount = 4 for ways_p=16.

Source files
------------

// File: rtl/bsg_lru_pseudo_tree_decode_pkg.sv
// Shared helpers for the pseudo-LRU tree decoder: the default way count and
// the node-to-level mapping of the heap-numbered tree.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_lru_pseudo_tree_decode_pkg;

  localparam int lru_default_ways_p = 8;

  // Level of a heap-numbered node: nodes 2^L-1 .. 2^(L+1)-2 live on level L.
  function automatic int lru_node_level(input int node);
    return $clog2(node + 2) - 1;
  endfunction

  // First node index on a given level.
  function automatic int lru_level_base(input int level);
    return (1 << level) - 1;
  endfunction

endpackage

// File: rtl/bsg_lru_pseudo_tree_decode_if.sv
// Bundle of the decoder's request (valid + way) and response (valid + tree
// data/mask) signals, for hooking the decoder up to a cache controller.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

interface bsg_lru_pseudo_tree_decode_if
  import bsg_lru_pseudo_tree_decode_pkg::*;
  #(parameter int ways_p = lru_default_ways_p);

  localparam int lg_ways_lp = `BSG_SAFE_CLOG2(ways_p);

  logic                  req_v;
  logic [lg_ways_lp-1:0] req_way_id;
  logic                  resp_v;
  logic [ways_p-2:0]     resp_data;
  logic [ways_p-2:0]     resp_mask;

  modport master (
    output req_v,
    output req_way_id,
    input  resp_v,
    input  resp_data,
    input  resp_mask
  );

  modport slave (
    input  req_v,
    input  req_way_id,
    output resp_v,
    output resp_data,
    output resp_mask
  );

endinterface

// File: rtl/bsg_lru_pseudo_tree_decode_comb.sv
// Combinational pseudo-LRU tree update decoder: marks the root-to-leaf path of
// the accessed way and points every path node away from that way.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_lru_pseudo_tree_decode_comb
  import bsg_lru_pseudo_tree_decode_pkg::*;
  #(parameter int ways_p = lru_default_ways_p
   ,localparam int lg_ways_lp = `BSG_SAFE_CLOG2(ways_p))
  (input  logic [lg_ways_lp-1:0] way_id_i
  ,output logic [ways_p-2:0]     data_o
  ,output logic [ways_p-2:0]     mask_o
  );

  // A node at level L is on the path when the top L way bits, read as an
  // index into that level, select it; the next way bit is the branch taken.
  for (genvar i = 0; i < ways_p-1; i++) begin : node
    localparam int level_lp  = lru_node_level(i);
    localparam int offset_lp = i - lru_level_base(level_lp);
    localparam int shift_lp  = lg_ways_lp - level_lp;

    logic on_path;

    assign on_path   = ((way_id_i >> shift_lp) == lg_ways_lp'(offset_lp));
    assign mask_o[i] = on_path;
    assign data_o[i] = on_path & ~way_id_i[lg_ways_lp-1-level_lp];
  end

endmodule

// File: rtl/bsg_lru_pseudo_tree_decode.sv
// Registered pseudo-LRU tree update decoder: one-cycle latency, accepts a new
// way every cycle, and clears data/mask on idle cycles so no stale write leaks.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_lru_pseudo_tree_decode
  import bsg_lru_pseudo_tree_decode_pkg::*;
  #(parameter int ways_p = lru_default_ways_p
   ,localparam int lg_ways_lp = `BSG_SAFE_CLOG2(ways_p))
  (input  logic                  clk_i
  ,input  logic                  reset_n_i
  ,input  logic                  v_i
  ,input  logic [lg_ways_lp-1:0] way_id_i
  ,output logic                  v_o
  ,output logic [ways_p-2:0]     data_o
  ,output logic [ways_p-2:0]     mask_o
  );

  logic [ways_p-2:0] data_n;
  logic [ways_p-2:0] mask_n;

  bsg_lru_pseudo_tree_decode_comb #(.ways_p(ways_p)) decode (
    .way_id_i (way_id_i),
    .data_o   (data_n),
    .mask_o   (mask_n)
  );

  // Idle cycles load zeros rather than holding, so a downstream writer that
  // ignores v_o still never re-applies an old mask.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
      mask_o <= '0;
    end else begin
      v_o    <= v_i;
      data_o <= v_i ? data_n : '0;
      mask_o <= v_i ? mask_n : '0;
    end
  end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_decode.sv
// Self-checking bench for bsg_lru_pseudo_tree_decode: table-driven vectors for
// 8 ways, tree-walk model sweeps for 2 and 16 ways, and async reset sequences.
module tb_bsg_lru_pseudo_tree_decode;

  typedef struct {
    logic       v;
    logic [2:0] way;
    logic       exp_v;
    logic [6:0] exp_data;
    logic [6:0] exp_mask;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t vecs[14];

  bsg_lru_pseudo_tree_decode_if #(.ways_p(8))  bus8  ();
  bsg_lru_pseudo_tree_decode_if #(.ways_p(2))  bus2  ();
  bsg_lru_pseudo_tree_decode_if #(.ways_p(16)) bus16 ();

  bsg_lru_pseudo_tree_decode #(.ways_p(8)) dut8 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (bus8.req_v),
    .way_id_i  (bus8.req_way_id),
    .v_o       (bus8.resp_v),
    .data_o    (bus8.resp_data),
    .mask_o    (bus8.resp_mask)
  );

  bsg_lru_pseudo_tree_decode #(.ways_p(2)) dut2 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (bus2.req_v),
    .way_id_i  (bus2.req_way_id),
    .v_o       (bus2.resp_v),
    .data_o    (bus2.resp_data),
    .mask_o    (bus2.resp_mask)
  );

  bsg_lru_pseudo_tree_decode #(.ways_p(16)) dut16 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (bus16.req_v),
    .way_id_i  (bus16.req_way_id),
    .v_o       (bus16.resp_v),
    .data_o    (bus16.resp_data),
    .mask_o    (bus16.resp_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the tree from the root, one way bit per level.
  task automatic tree_model(input int lg, input int way, output logic [31:0] d, output logic [31:0] m);
    int nd;
    int b;
    nd = 0;
    d  = '0;
    m  = '0;
    for (int l = 0; l < lg; l++) begin
      b     = (way >> (lg - 1 - l)) & 1;
      m[nd] = 1'b1;
      d[nd] = (b == 0);
      nd    = 2 * nd + 1 + b;
    end
  endtask

  task automatic apply_stimulus(input logic v8, input logic [2:0] w8);
    bus8.req_v      = v8;
    bus8.req_way_id = w8;
  endtask

  task automatic check_zero_all(input string tag);
    check_value({tag, " v8"},     32'(bus8.resp_v),     32'd0);
    check_value({tag, " data8"},  32'(bus8.resp_data),  32'd0);
    check_value({tag, " mask8"},  32'(bus8.resp_mask),  32'd0);
    check_value({tag, " v2"},     32'(bus2.resp_v),     32'd0);
    check_value({tag, " mask2"},  32'(bus2.resp_mask),  32'd0);
    check_value({tag, " v16"},    32'(bus16.resp_v),    32'd0);
    check_value({tag, " mask16"}, 32'(bus16.resp_mask), 32'd0);
  endtask

  initial begin
    logic [31:0] md;
    logic [31:0] mm;

    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    apply_stimulus(1'b0, 3'd0);
    bus2.req_v       = 1'b0;
    bus2.req_way_id  = 1'b0;
    bus16.req_v      = 1'b0;
    bus16.req_way_id = 4'd0;

    vecs[0]  = '{1'b1, 3'd0, 1'b1, 7'b0001011, 7'b0001011};
    vecs[1]  = '{1'b1, 3'd1, 1'b1, 7'b0000011, 7'b0001011};
    vecs[2]  = '{1'b1, 3'd2, 1'b1, 7'b0010001, 7'b0010011};
    vecs[3]  = '{1'b1, 3'd3, 1'b1, 7'b0000001, 7'b0010011};
    vecs[4]  = '{1'b1, 3'd4, 1'b1, 7'b0100100, 7'b0100101};
    vecs[5]  = '{1'b1, 3'd5, 1'b1, 7'b0000100, 7'b0100101};
    vecs[6]  = '{1'b1, 3'd6, 1'b1, 7'b1000000, 7'b1000101};
    vecs[7]  = '{1'b1, 3'd7, 1'b1, 7'b0000000, 7'b1000101};
    vecs[8]  = '{1'b0, 3'd3, 1'b0, 7'b0000000, 7'b0000000};
    vecs[9]  = '{1'b1, 3'd5, 1'b1, 7'b0000100, 7'b0100101};
    vecs[10] = '{1'b1, 3'd2, 1'b1, 7'b0010001, 7'b0010011};
    vecs[11] = '{1'b0, 3'd7, 1'b0, 7'b0000000, 7'b0000000};
    vecs[12] = '{1'b1, 3'd0, 1'b1, 7'b0001011, 7'b0001011};
    vecs[13] = '{1'b1, 3'd7, 1'b1, 7'b0000000, 7'b1000101};

    #1 reset_n = 1'b0;
    #1 check_zero_all("reset");
    repeat (2) @(posedge clk);
    #1 check_zero_all("reset held");

    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 14; k++) begin
      apply_stimulus(vecs[k].v, vecs[k].way);
      @(posedge clk);
      #1;
      check_value($sformatf("vec%0d v_o", k),    32'(bus8.resp_v),    32'(vecs[k].exp_v));
      check_value($sformatf("vec%0d data_o", k), 32'(bus8.resp_data), 32'(vecs[k].exp_data));
      check_value($sformatf("vec%0d mask_o", k), 32'(bus8.resp_mask), 32'(vecs[k].exp_mask));
      if (vecs[k].v) begin
        tree_model(3, int'(vecs[k].way), md, mm);
        check_value($sformatf("vec%0d model data", k), 32'(bus8.resp_data), md);
        check_value($sformatf("vec%0d model mask", k), 32'(bus8.resp_mask), mm);
        check_value($sformatf("vec%0d popcount", k), 32'($countones(bus8.resp_mask)), 32'd3);
        check_value($sformatf("vec%0d data off-path", k), 32'(bus8.resp_data & ~bus8.resp_mask), 32'd0);
      end
      @(negedge clk);
    end
    apply_stimulus(1'b0, 3'd0);

    // ways_p=2: single node, data is the inverted way bit
    for (int w = 0; w < 2; w++) begin
      bus2.req_v      = 1'b1;
      bus2.req_way_id = w[0];
      @(posedge clk);
      #1;
      check_value($sformatf("w2 way%0d v_o", w),    32'(bus2.resp_v),    32'd1);
      check_value($sformatf("w2 way%0d mask_o", w), 32'(bus2.resp_mask), 32'd1);
      check_value($sformatf("w2 way%0d data_o", w), 32'(bus2.resp_data), (w == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    bus2.req_v = 1'b0;
    @(posedge clk);
    #1;
    check_value("w2 idle v_o",    32'(bus2.resp_v),    32'd0);
    check_value("w2 idle mask_o", 32'(bus2.resp_mask), 32'd0);
    @(negedge clk);

    // ways_p=16: back-to-back sweep of every way
    for (int w = 0; w < 16; w++) begin
      bus16.req_v      = 1'b1;
      bus16.req_way_id = w[3:0];
      @(posedge clk);
      #1;
      tree_model(4, w, md, mm);
      check_value($sformatf("w16 way%0d v_o", w),      32'(bus16.resp_v),    32'd1);
      check_value($sformatf("w16 way%0d data_o", w),   32'(bus16.resp_data), md);
      check_value($sformatf("w16 way%0d mask_o", w),   32'(bus16.resp_mask), mm);
      check_value($sformatf("w16 way%0d popcount", w), 32'($countones(bus16.resp_mask)), 32'd4);
      @(negedge clk);
    end
    bus16.req_v = 1'b0;

    // Async reset between edges while a valid result is on the outputs
    apply_stimulus(1'b1, 3'd0);
    @(posedge clk);
    #1;
    check_value("pre-reset v_o",    32'(bus8.resp_v),    32'd1);
    check_value("pre-reset mask_o", 32'(bus8.resp_mask), 32'b0001011);
    #2 reset_n = 1'b0;
    #1;
    check_value("async reset v_o",    32'(bus8.resp_v),    32'd0);
    check_value("async reset data_o", 32'(bus8.resp_data), 32'd0);
    check_value("async reset mask_o", 32'(bus8.resp_mask), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b1, 3'd6);
    #2;
    check_value("released no edge v_o", 32'(bus8.resp_v), 32'd0);
    @(posedge clk);
    #1;
    check_value("post-reset v_o",    32'(bus8.resp_v),    32'd1);
    check_value("post-reset data_o", 32'(bus8.resp_data), 32'b1000000);
    check_value("post-reset mask_o", 32'(bus8.resp_mask), 32'b1000101);
    @(negedge clk);
    apply_stimulus(1'b0, 3'd0);
    @(posedge clk);
    #1;
    check_value("final idle v_o",    32'(bus8.resp_v),    32'd0);
    check_value("final idle mask_o", 32'(bus8.resp_mask), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
